// File: rtl/isp_rgb888_packer_if.sv
// Stream bundle between the ISP gamma output, the RGB888 packer and the frame writer.
// The slave modport is the packer's view; the master modport drives it.
interface isp_rgb888_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/isp_rgb888_packer.sv
// RGB888 packer: rounds/saturates 12-bit channels to 8 bits, repacks the byte
// stream of two-pixel beats into 32-bit words through a 12-byte elastic buffer,
// and marks start-of-frame / end-of-line / end-of-frame from word/line counters.
module isp_rgb888_packer #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080
) (
  input logic                  clock,
  input logic                  reset,
  isp_rgb888_packer_if.slave   bus
);

  localparam int WPL = IMG_WIDTH * 3 / 4;
  localparam int WW  = $clog2(WPL + 1);
  localparam int HW  = $clog2(IMG_HEIGHT + 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WPL - 1);
  localparam logic [HW-1:0] LINE_LAST = HW'(IMG_HEIGHT - 1);

  // Round to nearest and clamp; 13-bit sum so 0xFF8..0xFFF cannot wrap to 0.
  function automatic logic [7:0] round_sat(input logic [11:0] c);
    logic [12:0] s;
    s = {1'b0, c} + 13'd8;
    if (s[12]) begin
      round_sat = 8'hFF;
    end else begin
      round_sat = s[11:4];
    end
  endfunction

  // Buffer holds bytes oldest-first at [7:0]; bytes at index >= count_r are kept zero.
  logic [95:0]   buf_r;
  logic [3:0]    count_r;
  logic [WW-1:0] word_cnt_r;
  logic [HW-1:0] line_cnt_r;

  logic [95:0]   buf_next_s;
  logic [95:0]   buf_shift_s;
  logic [3:0]    count_next_s;
  logic [3:0]    base_s;
  logic [47:0]   beat_bytes_s;
  logic [WW-1:0] word_cnt_next_s;
  logic [HW-1:0] line_cnt_next_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          push_s;
  logic          pop_s;

  // Handshake qualifiers come from registered occupancy only.
  always_comb begin
    in_ready_s  = !reset && (count_r <= 4'd6);
    out_valid_s = (count_r >= 4'd4);
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
  end

  // Convert one beat into six bytes in stream order R0 G0 B0 R1 G1 B1.
  always_comb begin
    beat_bytes_s = {round_sat(bus.in_data[11:0]),  round_sat(bus.in_data[23:12]),
                    round_sat(bus.in_data[35:24]), round_sat(bus.in_data[47:36]),
                    round_sat(bus.in_data[59:48]), round_sat(bus.in_data[71:60])};
  end

  // Next buffer contents: drop the head word on pop, append the beat at the tail on push.
  always_comb begin
    buf_shift_s  = buf_r;
    base_s       = count_r;
    buf_next_s   = buf_r;
    count_next_s = count_r;
    if (pop_s) begin
      buf_shift_s = {32'd0, buf_r[95:32]};
      base_s      = count_r - 4'd4;
    end else begin
      buf_shift_s = buf_r;
      base_s      = count_r;
    end
    if (push_s) begin
      buf_next_s = buf_shift_s | ({48'd0, beat_bytes_s} << {base_s, 3'b000});
    end else begin
      buf_next_s = buf_shift_s;
    end
    count_next_s = base_s + (push_s ? 4'd6 : 4'd0);
  end

  // Word-in-line and line-in-frame counters advance on each word transfer.
  always_comb begin
    word_cnt_next_s = word_cnt_r;
    line_cnt_next_s = line_cnt_r;
    if (pop_s) begin
      if (word_cnt_r == WORD_LAST) begin
        word_cnt_next_s = '0;
        if (line_cnt_r == LINE_LAST) begin
          line_cnt_next_s = '0;
        end else begin
          line_cnt_next_s = line_cnt_r + 1'b1;
        end
      end else begin
        word_cnt_next_s = word_cnt_r + 1'b1;
        line_cnt_next_s = line_cnt_r;
      end
    end else begin
      word_cnt_next_s = word_cnt_r;
      line_cnt_next_s = line_cnt_r;
    end
  end

  // State registers; reset discards buffered bytes and restarts the frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_r      <= 96'd0;
      count_r    <= 4'd0;
      word_cnt_r <= '0;
      line_cnt_r <= '0;
    end else begin
      buf_r      <= buf_next_s;
      count_r    <= count_next_s;
      word_cnt_r <= word_cnt_next_s;
      line_cnt_r <= line_cnt_next_s;
    end
  end

  // Outputs decode registered state, so they hold steady under backpressure.
  always_comb begin
    bus.in_ready  = in_ready_s;
    bus.out_valid = out_valid_s;
    bus.out_data  = out_valid_s ? buf_r[31:0] : 32'd0;
    bus.out_sof   = out_valid_s && (word_cnt_r == '0) && (line_cnt_r == '0);
    bus.out_eol   = out_valid_s && (word_cnt_r == WORD_LAST);
    bus.out_eof   = out_valid_s && (word_cnt_r == WORD_LAST) && (line_cnt_r == LINE_LAST);
  end

endmodule

// File: tb/tb_isp_rgb888_packer.sv
// Directed bench for isp_rgb888_packer with a small 8x2 frame.
module tb_isp_rgb888_packer;
  localparam int W = 8;
  localparam int H = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  isp_rgb888_packer_if bus();

  isp_rgb888_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
    int          cyc;
  } word_t;

  typedef struct {
    string       name;
    logic [71:0] beat;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  word_t wq[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    beats = 0;
  int    checks = 0;
  int    errors = 0;
  int    wb = 0;
  int    bb = 0;
  vec_t  tbl[4];

  // Records every word and beat transfer with its cycle number.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && bus.out_valid && bus.out_ready)
      wq.push_back('{bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof, cyc});
    if (!reset && bus.in_valid && bus.in_ready) begin
      beats <= beats + 1;
      beat_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic word_t get_word(input int idx);
    word_t w;
    w = '{32'hxxxxxxxx, 1'bx, 1'bx, 1'bx, -1};
    if (idx < wq.size()) w = wq[idx];
    return w;
  endfunction

  function automatic logic [71:0] seq_beat(input int i);
    logic [71:0] d;
    d = 72'd0;
    for (int k = 0; k < 6; k++) d[71-12*k -: 12] = 12'((6*i + k) * 16);
    return d;
  endfunction

  function automatic logic [31:0] seq_word(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = 72'd0;
    @(negedge clock);
    reset = 1'b0;
    wb = wq.size();
    bb = beat_cyc.size();
  endtask

  task automatic send(input logic [71:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_data = 72'd0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (wq.size() < wb + n && i < budget) begin
      @(negedge clock);
      i++;
    end
    chk(name, 32'(wq.size() - wb), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=hang expected=finish");
    $fatal(1);
  end

  initial begin
    word_t w;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = 72'd0;

    tbl[0] = '{"spec_beat", {12'h123, 12'hFFF, 12'h008, 12'h000, 12'h7F8, 12'h010},
               32'h0001FF12, 32'h00000180, 32'h00000000};
    tbl[1] = '{"round_edges", {12'h007, 12'h008, 12'hFF7, 12'hFF8, 12'hFFF, 12'h000},
               32'hFFFF0100, 32'h000000FF, 32'h00000000};
    tbl[2] = '{"mixed", {12'h0F0, 12'h555, 12'hAAA, 12'h017, 12'h018, 12'h800},
               32'h01AB550F, 32'h00008002, 32'h00000000};
    tbl[3] = '{"all_ones", {6{12'hFFF}}, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000};

    // Reset state while reset is held
    #7;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_flags", 32'({bus.out_sof, bus.out_eol, bus.out_eof}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Conversion and packing table
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bus.out_ready = 1'b1;
      send(tbl[v].beat);
      #1;
      chk({tbl[v].name, "_latency"}, 32'(bus.out_valid), 32'd1);
      send(72'd0);
      idle();
      wait_words(3, 20, {tbl[v].name, "_count"});
      chk({tbl[v].name, "_w0"}, get_word(wb).data, tbl[v].w0);
      chk({tbl[v].name, "_w1"}, get_word(wb+1).data, tbl[v].w1);
      chk({tbl[v].name, "_w2"}, get_word(wb+2).data, tbl[v].w2);
      chk({tbl[v].name, "_sof"}, 32'(get_word(wb).sof), 32'd1);
      chk({tbl[v].name, "_rate"}, 32'(get_word(wb+2).cyc - get_word(wb).cyc), 32'd2);
    end

    // Backpressure: buffer fills after two beats and the head word holds
    do_reset();
    send(tbl[0].beat);
    @(negedge clock);
    bus.in_data = 72'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("bp_hold_data", bus.out_data, 32'h0001FF12);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    chk("bp_beats", 32'(beat_cyc.size() - bb), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_words(3, 20, "bp_drain_count");
    chk("bp_w0", get_word(wb).data, 32'h0001FF12);
    chk("bp_w1", get_word(wb+1).data, 32'h00000180);
    chk("bp_w2", get_word(wb+2).data, 32'h00000000);
    chk("bp_consecutive", 32'(get_word(wb+2).cyc - get_word(wb).cyc), 32'd2);
    @(negedge clock);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Frame markers over a full 8x2 frame plus the first word of the next frame
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(seq_beat(i));
    idle();
    wait_words(12, 60, "frame_count");
    for (int j = 0; j < 12; j++) begin
      w = get_word(wb + j);
      chk($sformatf("frame_w%0d_data", j), w.data, seq_word(j));
      chk($sformatf("frame_w%0d_flags", j), 32'({w.sof, w.eol, w.eof}),
          32'({(j == 0), (j == 5 || j == 11), (j == 11)}));
    end
    send(seq_beat(8));
    idle();
    wait_words(13, 20, "frame_wrap_count");
    w = get_word(wb + 12);
    chk("frame_wrap_data", w.data, seq_word(12));
    chk("frame_wrap_flags", 32'({w.sof, w.eol, w.eof}), 32'b100);

    // Simultaneous push and pop with six bytes buffered
    do_reset();
    send(seq_beat(0));
    @(negedge clock);
    bus.out_ready = 1'b1;
    bus.in_data = seq_beat(1);
    @(posedge clock);
    #1;
    chk("pp_in_ready_cnt8", 32'(bus.in_ready), 32'd0);
    chk("pp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pp_head", bus.out_data, seq_word(1));
    idle();
    wait_words(3, 20, "pp_count");
    chk("pp_w0", get_word(wb).data, seq_word(0));
    chk("pp_w1", get_word(wb+1).data, seq_word(1));
    chk("pp_w2", get_word(wb+2).data, seq_word(2));
    chk("pp_same_cycle", 32'(beat_cyc[bb+1]), 32'(get_word(wb).cyc));

    // Reset in the middle of a frame with bytes buffered
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(seq_beat(i));
    idle();
    wait_words(4, 20, "mid_count");
    repeat (3) @(negedge clock);
    chk("mid_exact_words", 32'(wq.size() - wb), 32'd4);
    chk("mid_valid_low", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    send(seq_beat(3));
    idle();
    chk("mid_valid_high", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_async_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_async_data", bus.out_data, 32'd0);
    chk("mid_async_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_async_flags", 32'({bus.out_sof, bus.out_eol, bus.out_eof}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wb = wq.size();
    @(negedge clock);
    chk("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rel_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(tbl[0].beat);
    idle();
    wait_words(1, 20, "mid_new_count");
    chk("mid_new_data", get_word(wb).data, 32'h0001FF12);
    chk("mid_new_sof", 32'(get_word(wb).sof), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
